// File: rtl/dtc_inverse_search.sv
// Preimage search: sweeps every probe vector through an attached combinational classifier and
// reports the lowest input mapping to the requested class plus the total number of matches.
module dtc_inverse_search #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 5,
  parameter int CNT_W = IN_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OUT_W-1:0] req_class,
  input  logic             abort,
  output logic [IN_W-1:0]  probe_inp,
  input  logic [OUT_W-1:0] probe_outp,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_found,
  output logic [IN_W-1:0]  rsp_first,
  output logic [CNT_W-1:0] rsp_count
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } state_t;

  localparam logic [IN_W-1:0] PROBE_LAST = '1;

  state_t           state;
  logic [OUT_W-1:0] class_q;

  // The rsp_* registers double as the scan accumulators; only rsp_valid qualifies them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      class_q   <= '0;
      probe_inp <= '0;
      rsp_valid <= 1'b0;
      rsp_found <= 1'b0;
      rsp_first <= '0;
      rsp_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            class_q   <= req_class;
            probe_inp <= '0;
            rsp_found <= 1'b0;
            rsp_first <= '0;
            rsp_count <= '0;
            req_ready <= 1'b0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (abort) begin
            rsp_found <= 1'b0;
            rsp_first <= '0;
            rsp_count <= '0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            if (probe_outp == class_q) begin
              rsp_count <= rsp_count + 1'b1;
              if (!rsp_found) begin
                rsp_found <= 1'b1;
                rsp_first <= probe_inp;
              end
            end
            if (probe_inp == PROBE_LAST) begin
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              probe_inp <= probe_inp + 1'b1;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtc_inverse_search.sv
// Directed bench for dtc_inverse_search with identity, constant and single-hit classifier models.
module tb_dtc_inverse_search;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_class;
  logic       abort;
  logic [8:0] probe_inp;
  logic [4:0] probe_outp;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_found;
  logic [8:0] rsp_first;
  logic [9:0] rsp_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned model  = 0;

  always #5 clk = ~clk;

  // 0: identity, 1: constant 5'b10110, 2: single hit at 9'h1FF
  always_comb begin
    probe_outp = '0;
    case (model)
      0: probe_outp = probe_inp[4:0];
      1: probe_outp = 5'b10110;
      default: probe_outp = (probe_inp == 9'h1FF) ? 5'd1 : 5'd0;
    endcase
  end

  dtc_inverse_search #(.IN_W(9), .OUT_W(5), .CNT_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_class (req_class),
    .abort     (abort),
    .probe_inp (probe_inp),
    .probe_outp(probe_outp),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_found (rsp_found),
    .rsp_first (rsp_first),
    .rsp_count (rsp_count)
  );

  task automatic start_req(input logic [4:0] cls);
    @(negedge clk);
    req_class = cls;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int unsigned cycles);
    cycles = 0;
    while (cycles < 700) begin
      @(posedge clk);
      cycles++;
      #1;
      if (rsp_valid) break;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_class = '0; abort = 1'b0; rsp_ready = 1'b0;
    #12;
    checks++;
    if ({req_ready, probe_inp, rsp_valid, rsp_found, rsp_first, rsp_count} !== {1'b1, 9'd0, 1'b0, 1'b0, 9'd0, 10'd0}) begin
      errors++;
      $display("FAIL reset_values got rdy=%0b probe=%0d v=%0b f=%0b first=%0d cnt=%0d want 1 0 0 0 0 0",
               req_ready, probe_inp, rsp_valid, rsp_found, rsp_first, rsp_count);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %0b want 1", req_ready);
    end
  endtask

  task automatic test_identity();
    int unsigned cyc;
    model = 0;
    start_req(5'd7);
    wait_rsp(cyc);
    checks++;
    if (cyc !== 512) begin
      errors++; $display("FAIL identity_latency got %0d want 512", cyc);
    end
    checks++;
    if ({rsp_found, rsp_first, rsp_count} !== {1'b1, 9'd7, 10'd16}) begin
      errors++; $display("FAIL identity_result got f=%0b first=%0d cnt=%0d want 1 7 16", rsp_found, rsp_first, rsp_count);
    end
    handshake();
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL identity_handshake got v=%0b rdy=%0b want 0 1", rsp_valid, req_ready);
    end
    checks++;
    if (rsp_count !== 10'd16) begin
      errors++; $display("FAIL identity_idle_hold got cnt=%0d want 16", rsp_count);
    end
  endtask

  task automatic test_constant();
    int unsigned cyc;
    model = 1;
    start_req(5'b10110);
    wait_rsp(cyc);
    checks++;
    if ({rsp_valid, rsp_found, rsp_first, rsp_count} !== {1'b1, 1'b1, 9'd0, 10'd512}) begin
      errors++; $display("FAIL const_all got v=%0b f=%0b first=%0d cnt=%0d want 1 1 0 512", rsp_valid, rsp_found, rsp_first, rsp_count);
    end
    handshake();
    start_req(5'b00000);
    wait_rsp(cyc);
    checks++;
    if ({rsp_valid, rsp_found, rsp_first, rsp_count} !== {1'b1, 1'b0, 9'd0, 10'd0}) begin
      errors++; $display("FAIL const_none got v=%0b f=%0b first=%0d cnt=%0d want 1 0 0 0", rsp_valid, rsp_found, rsp_first, rsp_count);
    end
    handshake();
  endtask

  task automatic test_single_hit();
    int unsigned cyc;
    model = 2;
    start_req(5'd1);
    wait_rsp(cyc);
    checks++;
    if ({rsp_valid, rsp_found, rsp_first, rsp_count} !== {1'b1, 1'b1, 9'h1FF, 10'd1}) begin
      errors++; $display("FAIL single_hit got v=%0b f=%0b first=%0h cnt=%0d want 1 1 1ff 1", rsp_valid, rsp_found, rsp_first, rsp_count);
    end
    checks++;
    if (probe_inp !== 9'h1FF) begin
      errors++; $display("FAIL probe_hold_last got %0h want 1ff", probe_inp);
    end
    handshake();
  endtask

  task automatic test_hold_resp();
    int unsigned cyc;
    model = 0;
    start_req(5'd3);
    wait_rsp(cyc);
    req_valid = 1'b1;
    req_class = 5'd9;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, req_ready, rsp_found, rsp_first, rsp_count} !== {1'b1, 1'b0, 1'b1, 9'd3, 10'd16}) begin
        errors++;
        $display("FAIL hold_resp cyc%0d got v=%0b rdy=%0b f=%0b first=%0d cnt=%0d want 1 0 1 3 16",
                 i, rsp_valid, req_ready, rsp_found, rsp_first, rsp_count);
      end
    end
    req_valid = 1'b0;
    handshake();
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL hold_release got v=%0b rdy=%0b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_abort();
    int unsigned cyc;
    logic seen;
    model = 0;
    start_req(5'd7);
    repeat (99) @(posedge clk);
    #1;
    checks++;
    if (probe_inp !== 9'd99 || rsp_count !== 10'd3) begin
      errors++; $display("FAIL abort_pre got probe=%0d cnt=%0d want 99 3", probe_inp, rsp_count);
    end
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, rsp_found, rsp_first, rsp_count} !== {1'b1, 1'b0, 1'b0, 9'd0, 10'd0}) begin
      errors++; $display("FAIL abort_mid got rdy=%0b v=%0b f=%0b first=%0d cnt=%0d want 1 0 0 0 0",
                         req_ready, rsp_valid, rsp_found, rsp_first, rsp_count);
    end
    seen = 1'b0;
    repeat (600) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_no_rsp got rsp_valid seen=1 want 0");
    end
    start_req(5'd7);
    repeat (511) @(posedge clk);
    #1;
    checks++;
    if (probe_inp !== 9'h1FF || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL abort_last_pre got probe=%0h v=%0b want 1ff 0", probe_inp, rsp_valid);
    end
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, rsp_count} !== {1'b1, 1'b0, 10'd0}) begin
      errors++; $display("FAIL abort_last got rdy=%0b v=%0b cnt=%0d want 1 0 0", req_ready, rsp_valid, rsp_count);
    end
    start_req(5'd31);
    wait_rsp(cyc);
    checks++;
    if (cyc !== 512 || {rsp_found, rsp_first, rsp_count} !== {1'b1, 9'd31, 10'd16}) begin
      errors++; $display("FAIL after_abort got lat=%0d f=%0b first=%0d cnt=%0d want 512 1 31 16", cyc, rsp_found, rsp_first, rsp_count);
    end
    handshake();
  endtask

  task automatic test_reset_mid_scan();
    model = 0;
    start_req(5'd7);
    repeat (200) @(posedge clk);
    #1;
    checks++;
    if (probe_inp !== 9'd200) begin
      errors++; $display("FAIL mid_reset_probe got %0d want 200", probe_inp);
    end
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, probe_inp, rsp_valid, rsp_found, rsp_first, rsp_count} !== {1'b1, 9'd0, 1'b0, 1'b0, 9'd0, 10'd0}) begin
      errors++; $display("FAIL mid_reset got rdy=%0b probe=%0d v=%0b f=%0b first=%0d cnt=%0d want 1 0 0 0 0 0",
                         req_ready, probe_inp, rsp_valid, rsp_found, rsp_first, rsp_count);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({req_ready, probe_inp, rsp_valid} !== {1'b1, 9'd0, 1'b0}) begin
      errors++; $display("FAIL mid_reset_release got rdy=%0b probe=%0d v=%0b want 1 0 0", req_ready, probe_inp, rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_constant();
    test_single_hit();
    test_hold_resp();
    test_abort();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
